// File: rtl/pu_pkg.sv
// Shared constants and types for the processingUnit operand feeder and PU-side blocks.
package pu_pkg;

    localparam int unsigned DATA_W   = 5;
    localparam int unsigned LANES    = 4;
    localparam int unsigned PIPE_LAT = 3;
    localparam int unsigned IDX_W    = $clog2(LANES);

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // One (activation, weight) lane entry
    typedef struct packed {
        logic [DATA_W-1:0] act;
        logic [DATA_W-1:0] wgt;
    } pair_t;

endpackage

// File: rtl/pu_operand_feeder_if.sv
// Valid/ready stream of (activation, weight) pairs into the operand feeder.
interface pu_operand_feeder_if;
    import pu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_act;
    logic [DATA_W-1:0] in_wgt;

    modport master (output in_valid, output in_act, output in_wgt, input in_ready);
    modport slave  (input in_valid, input in_act, input in_wgt, output in_ready);

endinterface

// File: rtl/pu_valid_pipe.sv
// PIPE_LAT-deep valid shift register tracking vectors inside the PU pipeline.
module pu_valid_pipe
    import pu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic res_valid_o,
    output logic busy_o
);

    logic [PIPE_LAT-1:0] pipe_q, pipe_d;
    logic                busy_q, busy_d;

    always_comb begin
        pipe_d = (pipe_q << 1) | PIPE_LAT'(en_i);
        busy_d = |pipe_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
            busy_q <= 1'b0;
        end else begin
            pipe_q <= pipe_d;
            busy_q <= busy_d;
        end
    end

    assign res_valid_o = pipe_q[PIPE_LAT-1];
    assign busy_o      = busy_q;

endmodule

// File: rtl/pu_operand_feeder.sv
// Packs a serial (act, wgt) stream into four PU lanes and pulses en_reg per vector.
// Optional zero-padded partial issue via flush_i when FEEDER_FLUSH_EN is defined.
module pu_operand_feeder
    import pu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    pu_operand_feeder_if.slave in_if,
`ifdef FEEDER_FLUSH_EN
    input  logic               flush_i,
`endif
    output logic [DATA_W-1:0]  a1_o,
    output logic [DATA_W-1:0]  a2_o,
    output logic [DATA_W-1:0]  a3_o,
    output logic [DATA_W-1:0]  a4_o,
    output logic [DATA_W-1:0]  w1_o,
    output logic [DATA_W-1:0]  w2_o,
    output logic [DATA_W-1:0]  w3_o,
    output logic [DATA_W-1:0]  w4_o,
    output logic               en_reg_o,
    output logic               res_valid_o,
    output logic               busy_o
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    pair_t            lane_q [LANES];
    pair_t            lane_d [LANES];
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             xfer_c;

    assign xfer_c = in_if.in_valid && ready_q;

    // Next-state, lane writes and registered handshake/enable
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        unique case (state_q)
            FILL: begin
                if (xfer_c) begin
                    lane_d[idx_q] = '{act: in_if.in_act, wgt: in_if.in_wgt};
                    if (idx_q == IDX_W'(LANES - 1)) begin
                        state_d = ISSUE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
`ifdef FEEDER_FLUSH_EN
                // Partial vector: pad every lane not yet written, then issue
                if (flush_i && (state_d == FILL) && (xfer_c || (idx_q != '0))) begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        if (i >= 32'(idx_d)) lane_d[IDX_W'(i)] = '0;
                    end
                    state_d = ISSUE;
                    idx_d   = '0;
                end
`endif
            end
            ISSUE:   state_d = FILL;
            default: state_d = FILL;
        endcase
        en_d    = (state_d == ISSUE);
        ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            lane_q  <= '{default: '0};
            en_q    <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            en_q    <= en_d;
            ready_q <= ready_d;
        end
    end

    pu_valid_pipe u_valid_pipe (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_q),
        .res_valid_o (res_valid_o),
        .busy_o      (busy_o)
    );

    assign in_if.in_ready = ready_q;
    assign en_reg_o       = en_q;
    assign a1_o = lane_q[0].act;
    assign a2_o = lane_q[1].act;
    assign a3_o = lane_q[2].act;
    assign a4_o = lane_q[3].act;
    assign w1_o = lane_q[0].wgt;
    assign w2_o = lane_q[1].wgt;
    assign w3_o = lane_q[2].wgt;
    assign w4_o = lane_q[3].wgt;

endmodule
